seq_alu: RTL

Arithmetic/logic unit sitting directly upstream of the accumulator register. Computes a result from the current accumulator value and a memory-buffer operand, drives the accumulator's 16-bit data input, and asserts its one-cycle write strobe. Simple operations complete in one cycle. Unsigned multiply and divide are iterative: 16 steps, with busy asserted while they run. Status flags and a secondary MR register (multiply high word or divide remainder) are held here for the control unit.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/seq_muldiv.sv | 74 +++++++
 rtl/seq_alu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, ALU sequencer states and the datapath word width.
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_NOT = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MPY = 4'd7,
    OP_DIV = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_WB   = 2'd2
  } alu_state_t;

  // Single-cycle opcodes occupy the low end of the opcode space.
  function automatic logic is_simple_op(input logic [3:0] op);
    return (op <= 4'd6);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned 16x16 multiply (shift-add) and 16/16 divide (restoring), one step per step pulse.
module seq_muldiv
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              done,
  output logic              div_mode,
  output logic              div_zero,
  output logic [WORD_W-1:0] lo,
  output logic [WORD_W-1:0] hi
);

  logic [31:0] acc_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [4:0]  cnt_r;
  logic        div_r;
  logic        dz_r;

  logic [16:0] mpy_sum_s;
  logic [31:0] mpy_nxt_s;
  logic [16:0] div_sh_s;
  logic [17:0] div_diff_s;
  logic [31:0] div_nxt_s;

  // Next value of the shift register for one multiply or one divide step.
  always_comb begin
    mpy_sum_s  = {1'b0, acc_r[31:16]} + (acc_r[0] ? {1'b0, b_r} : 17'd0);
    mpy_nxt_s  = {mpy_sum_s, acc_r[15:1]};
    div_sh_s   = {acc_r[31:16], acc_r[15]};
    div_diff_s = {1'b0, div_sh_s} - {2'b00, b_r};
    if (div_diff_s[17]) begin
      div_nxt_s = {div_sh_s[15:0], acc_r[14:0], 1'b0};
    end else begin
      div_nxt_s = {div_diff_s[15:0], acc_r[14:0], 1'b1};
    end
  end

  // Operand latch and iteration register; the low half starts as the multiplier/dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 32'h0000_0000;
      a_r   <= 16'h0000;
      b_r   <= 16'h0000;
      cnt_r <= 5'd0;
      div_r <= 1'b0;
      dz_r  <= 1'b0;
    end else if (load) begin
      acc_r <= {16'h0000, a};
      a_r   <= a;
      b_r   <= b;
      cnt_r <= 5'd0;
      div_r <= is_div;
      dz_r  <= is_div && (b == 16'h0000);
    end else if (step) begin
      acc_r <= div_r ? div_nxt_s : mpy_nxt_s;
      cnt_r <= cnt_r + 5'd1;
    end
  end

  assign done     = step && (cnt_r == 5'd15);
  assign div_mode = div_r;
  assign div_zero = dz_r;
  // Divide by zero still runs all steps, but the answer is fixed rather than taken from the iteration.
  assign lo = dz_r ? 16'hFFFF : acc_r[15:0];
  assign hi = dz_r ? a_r : acc_r[31:16];

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU feeding the accumulator: single-cycle logic/arithmetic ops plus iterative MPY/DIV.
module seq_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] acc_data,
  input  logic [WIDTH-1:0] mbr_data,
  output logic [WIDTH-1:0] alu2acc,
  output logic             acc_alu_io_rw,
  output logic [WIDTH-1:0] mr_data,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);

  alu_state_t  state_r, state_nxt_s;
  logic        load_s, step_s, wr_simple_s, wr_wb_s;
  logic [16:0] sum_s, dif_s;
  logic [15:0] simple_res_s;
  logic        simple_c_s, simple_v_s;
  logic        md_done_s, md_div_s, md_dz_s;
  logic [15:0] md_lo_s, md_hi_s;

  logic [15:0] res_r, mr_r;
  logic        strobe_r, busy_r, z_r, n_r, c_r, v_r, dz_r;

  // Single-cycle result and carry/overflow for ops 0-6.
  always_comb begin
    sum_s        = {1'b0, acc_data} + {1'b0, mbr_data};
    dif_s        = {1'b0, acc_data} - {1'b0, mbr_data};
    simple_res_s = 16'h0000;
    simple_c_s   = 1'b0;
    simple_v_s   = 1'b0;
    case (op)
      OP_ADD: begin
        simple_res_s = sum_s[15:0];
        simple_c_s   = sum_s[16];
        simple_v_s   = (acc_data[15] == mbr_data[15]) && (sum_s[15] != acc_data[15]);
      end
      OP_SUB: begin
        simple_res_s = dif_s[15:0];
        simple_c_s   = dif_s[16];
        simple_v_s   = (acc_data[15] != mbr_data[15]) && (dif_s[15] != acc_data[15]);
      end
      OP_AND:  simple_res_s = acc_data & mbr_data;
      OP_OR:   simple_res_s = acc_data | mbr_data;
      OP_NOT:  simple_res_s = ~acc_data;
      OP_SHL: begin
        simple_res_s = {acc_data[14:0], 1'b0};
        simple_c_s   = acc_data[15];
      end
      OP_SHR: begin
        simple_res_s = {1'b0, acc_data[15:1]};
        simple_c_s   = acc_data[0];
      end
      default: simple_res_s = 16'h0000;
    endcase
  end

  // Sequencer next state; starts are only honoured in IDLE, reserved opcodes are dropped.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    wr_simple_s = 1'b0;
    wr_wb_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (is_simple_op(op)) begin
            wr_simple_s = 1'b1;
          end else if ((op == OP_MPY) || (op == OP_DIV)) begin
            load_s      = 1'b1;
            state_nxt_s = ST_ITER;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (md_done_s) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_ITER;
        end
      end
      ST_WB: begin
        wr_wb_s     = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign step_s = (state_r == ST_ITER);

  seq_muldiv u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .step     (step_s),
    .is_div   (op == OP_DIV),
    .a        (acc_data),
    .b        (mbr_data),
    .done     (md_done_s),
    .div_mode (md_div_s),
    .div_zero (md_dz_s),
    .lo       (md_lo_s),
    .hi       (md_hi_s)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result, MR, flag, strobe and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r    <= 16'h0000;
      mr_r     <= 16'h0000;
      strobe_r <= 1'b0;
      busy_r   <= 1'b0;
      z_r      <= 1'b0;
      n_r      <= 1'b0;
      c_r      <= 1'b0;
      v_r      <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      strobe_r <= wr_simple_s | wr_wb_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
      if (wr_simple_s) begin
        res_r <= simple_res_s;
        z_r   <= (simple_res_s == 16'h0000);
        n_r   <= simple_res_s[15];
        c_r   <= simple_c_s;
        v_r   <= simple_v_s;
        dz_r  <= 1'b0;
      end else if (wr_wb_s) begin
        res_r <= md_lo_s;
        mr_r  <= md_hi_s;
        z_r   <= (md_lo_s == 16'h0000);
        n_r   <= md_lo_s[15];
        c_r   <= !md_div_s && (md_hi_s != 16'h0000);
        v_r   <= 1'b0;
        dz_r  <= md_dz_s;
      end
    end
  end

  assign alu2acc       = res_r;
  assign mr_data       = mr_r;
  assign acc_alu_io_rw = strobe_r;
  assign busy          = busy_r;
  assign flag_z        = z_r;
  assign flag_n        = n_r;
  assign flag_c        = c_r;
  assign flag_v        = v_r;
  assign flag_dz       = dz_r;

endmodule
